hit_memory_storage: RTL and testbench

//  Hit-storage subsystem: a generator streams (SSID, hitInfo) write requests into
//  a block-RAM store. The store keeps hit information per SSID, supports bulk

---
 rtl/hit_memory_storage_pkg.sv | 28 ++
 rtl/hit_memory_storage_if.sv | 31 +++
 rtl/hit_memory_storage_ssid_address_gen.sv | 49 ++++
 rtl/hit_memory_storage.sv | 134 +++++++++++++
 tb/tb_hit_memory_storage.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hit_memory_storage_pkg.sv
// =====================================================================
// hit_memory_storage_pkg : shared defaults, LFSR constants, store states
// Rev 1.0
// =====================================================================
`default_nettype none

package hit_memory_storage_pkg;

    localparam int unsigned c_ssidbits_def  = 8;
    localparam int unsigned c_ncols_him_def = 16;

    // Galois form of x^32+x^22+x^2+x+1
    localparam logic [31:0] c_lfsr_mask = 32'h8020_0003;
    localparam logic [31:0] c_lfsr_seed = 32'hACE1_2345;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_READ  = 2'd2
    } store_state_e;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? c_lfsr_mask : 32'h0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hit_memory_storage_if.sv
// =====================================================================
// hit_memory_storage_if : write-request and read-out bus of the hit store
// Rev 1.0
// =====================================================================
`default_nettype none

interface hit_memory_storage_if #(
    parameter int SSIDBITS  = 8,
    parameter int NCOLS_HIM = 16
);
    logic                  storageReady;
    logic                  newAddress;
    logic [SSIDBITS-1:0]   SSID;
    logic [NCOLS_HIM-1:0]  hitInfo;
    logic                  readReady;
    logic                  readDone;
    logic [SSIDBITS-1:0]   readSSID;
    logic [NCOLS_HIM-1:0]  readHitInfo;

    modport master (
        output storageReady, newAddress, SSID, hitInfo,
        output readReady, readDone, readSSID, readHitInfo
    );

    modport slave (
        input storageReady, newAddress, SSID, hitInfo,
        input readReady, readDone, readSSID, readHitInfo
    );
endinterface

`default_nettype wire

// File: rtl/hit_memory_storage_ssid_address_gen.sv
// =====================================================================
// ssid_address_gen : sequential SSID counter with LFSR hit data source
// Rev 1.0
// =====================================================================
`default_nettype none

module ssid_address_gen
    import hit_memory_storage_pkg::*;
#(
    parameter int          SSIDBITS   = c_ssidbits_def,
    parameter int          NCOLS_HIM  = c_ncols_him_def,
    parameter int          NADDRESSES = 2**SSIDBITS,
    parameter logic [31:0] LFSR_SEED  = c_lfsr_seed
) (
    input  wire logic                 clock,
    input  wire logic                 resetN,
    input  wire logic                 storageReady_i,
    output logic                      newAddress_o,
    output logic [SSIDBITS-1:0]       ssid_o,
    output logic [NCOLS_HIM-1:0]      hitInfo_o
);

    // Counter must hold NADDRESSES itself and also cover the SSID slice
    localparam int c_cnt_need = $clog2(NADDRESSES + 1);
    localparam int c_cnt_w    = (c_cnt_need > SSIDBITS) ? c_cnt_need : SSIDBITS;
    localparam logic [c_cnt_w-1:0] c_naddr = c_cnt_w'(NADDRESSES);

    logic [c_cnt_w-1:0] count_q;
    logic [31:0]        lfsr_q;
    logic               w_fire;

    assign w_fire       = storageReady_i && (count_q < c_naddr);
    assign newAddress_o = w_fire;
    assign ssid_o       = count_q[SSIDBITS-1:0];
    assign hitInfo_o    = lfsr_q[NCOLS_HIM-1:0];

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count_q <= '0;
            lfsr_q  <= LFSR_SEED;
        end else if (w_fire) begin
            count_q <= count_q + c_cnt_w'(1);
            lfsr_q  <= lfsr_step(lfsr_q);
        end
    end

endmodule

`default_nettype wire

// File: rtl/hit_memory_storage.sv
// =====================================================================
// hit_memory_storage : per-SSID hit store fed by the address generator
// Rev 1.0
// =====================================================================
`default_nettype none

module hit_memory_storage
    import hit_memory_storage_pkg::*;
#(
    parameter int          SSIDBITS   = c_ssidbits_def,
    parameter int          NCOLS_HIM  = c_ncols_him_def,
    parameter int          NADDRESSES = 2**SSIDBITS,
    parameter logic [31:0] LFSR_SEED  = c_lfsr_seed
) (
    input  wire logic             clock,
    input  wire logic             resetN,
    input  wire logic             clearMemory,
    input  wire logic             readMemory,
    hit_memory_storage_if.master  bus
);

    localparam int                  c_depth = 2**SSIDBITS;
    localparam logic [SSIDBITS-1:0] c_last  = '1;

    store_state_e           state_q;
    logic [SSIDBITS-1:0]    addr_q;
    logic [c_depth-1:0]     valid_q;
    logic                   rd_ready_q;
    logic                   rd_done_q;
    logic [SSIDBITS-1:0]    rd_ssid_q;
    logic [NCOLS_HIM-1:0]   mem_q [c_depth];
    logic [NCOLS_HIM-1:0]   mem_rd_q;

    logic                   w_storage_ready;
    logic                   w_new_address;
    logic [SSIDBITS-1:0]    w_ssid;
    logic [NCOLS_HIM-1:0]   w_hit_info;

    assign w_storage_ready = (state_q == ST_IDLE);

    ssid_address_gen #(
        .SSIDBITS   (SSIDBITS),
        .NCOLS_HIM  (NCOLS_HIM),
        .NADDRESSES (NADDRESSES),
        .LFSR_SEED  (LFSR_SEED)
    ) u_gen (
        .clock          (clock),
        .resetN         (resetN),
        .storageReady_i (w_storage_ready),
        .newAddress_o   (w_new_address),
        .ssid_o         (w_ssid),
        .hitInfo_o      (w_hit_info)
    );

    // Writes only fire in IDLE because the generator is gated by storageReady
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ST_CLEAR;
            addr_q     <= '0;
            valid_q    <= '0;
            rd_ready_q <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_ssid_q  <= '0;
        end else begin
            rd_ready_q <= 1'b0;
            rd_done_q  <= 1'b0;
            if (w_new_address) begin
                valid_q[w_ssid] <= 1'b1;
            end
            case (state_q)
                ST_CLEAR: begin
                    valid_q[addr_q] <= 1'b0;
                    if (clearMemory) begin
                        addr_q <= '0;
                    end else if (addr_q == c_last) begin
                        addr_q  <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        addr_q <= addr_q + SSIDBITS'(1);
                    end
                end
                ST_IDLE: begin
                    if (clearMemory) begin
                        addr_q  <= '0;
                        state_q <= ST_CLEAR;
                    end else if (readMemory) begin
                        addr_q  <= '0;
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (clearMemory) begin
                        addr_q  <= '0;
                        state_q <= ST_CLEAR;
                    end else if (rd_done_q) begin
                        // last word is on the outputs this cycle; release the store next
                        state_q <= ST_IDLE;
                    end else begin
                        rd_ready_q <= valid_q[addr_q];
                        rd_ssid_q  <= addr_q;
                        rd_done_q  <= (addr_q == c_last);
                        if (addr_q != c_last) begin
                            addr_q <= addr_q + SSIDBITS'(1);
                        end
                    end
                end
                default: begin
                    addr_q  <= '0;
                    state_q <= ST_CLEAR;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_new_address) begin
            mem_q[w_ssid] <= w_hit_info;
        end
        mem_rd_q <= mem_q[addr_q];
    end

    assign bus.storageReady = w_storage_ready;
    assign bus.newAddress   = w_new_address;
    assign bus.SSID         = w_ssid;
    assign bus.hitInfo      = w_hit_info;
    assign bus.readReady    = rd_ready_q;
    assign bus.readDone     = rd_done_q;
    assign bus.readSSID     = rd_ssid_q;
    // Empty entries read back as zero regardless of stale RAM contents
    assign bus.readHitInfo  = rd_ready_q ? mem_rd_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_hit_memory_storage.sv
// =====================================================================
// tb_hit_memory_storage : scoreboard bench for hit_memory_storage
// Rev 1.0
// =====================================================================
`default_nettype none

module tb_hit_memory_storage;

    localparam int SB = 4;
    localparam int NC = 16;
    localparam int NA = 4;
    localparam logic [15:0] HIT_REF [4] = '{16'h2345, 16'h91A1, 16'h48D3, 16'h246A};

    logic clock       = 1'b0;
    logic resetN      = 1'b0;
    logic clearMemory = 1'b0;
    logic readMemory  = 1'b0;

    always #5 clock = ~clock;

    hit_memory_storage_if #(.SSIDBITS(SB), .NCOLS_HIM(NC)) bus ();

    hit_memory_storage #(
        .SSIDBITS   (SB),
        .NCOLS_HIM  (NC),
        .NADDRESSES (NA),
        .LFSR_SEED  (32'hACE12345)
    ) dut (
        .clock       (clock),
        .resetN      (resetN),
        .clearMemory (clearMemory),
        .readMemory  (readMemory),
        .bus         (bus)
    );

    typedef struct packed {
        logic [3:0]  ssid;
        logic [15:0] data;
    } wr_t;

    typedef struct packed {
        logic [3:0]  ssid;
        logic [15:0] data;
        logic        ready;
        logic        done;
    } rd_t;

    wr_t wq[$];
    rd_t rq[$];
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic push_write(input int i);
        wr_t w;
        w.ssid = 4'(i);
        w.data = HIT_REF[i];
        wq.push_back(w);
    endtask

    task automatic push_read(input int s, input logic [15:0] d, input logic rdy, input logic dn);
        rd_t r;
        r.ssid  = 4'(s);
        r.data  = d;
        r.ready = rdy;
        r.done  = dn;
        rq.push_back(r);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_storageReady"}, 32'(bus.storageReady), 32'd0);
        chk({tag, "_newAddress"},   32'(bus.newAddress),   32'd0);
        chk({tag, "_readReady"},    32'(bus.readReady),    32'd0);
        chk({tag, "_readDone"},     32'(bus.readDone),     32'd0);
        chk({tag, "_readSSID"},     32'(bus.readSSID),     32'd0);
        chk({tag, "_readHitInfo"},  32'(bus.readHitInfo),  32'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write or read word
    always @(negedge clock) begin : mon
        wr_t w;
        rd_t r;
        if (resetN) begin
            if (bus.newAddress) begin
                if (wq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got SSID %0h want none", bus.SSID);
                end else begin
                    w = wq.pop_front();
                    chk("wr_ssid", 32'(bus.SSID), 32'(w.ssid));
                    chk("wr_hit",  32'(bus.hitInfo), 32'(w.data));
                end
            end
            if (bus.readReady || bus.readDone) begin
                if (rq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_read: got readSSID %0h want none", bus.readSSID);
                end else begin
                    r = rq.pop_front();
                    chk("rd_ssid",  32'(bus.readSSID),    32'(r.ssid));
                    chk("rd_hit",   32'(bus.readHitInfo), 32'(r.data));
                    chk("rd_ready", 32'(bus.readReady),   32'(r.ready));
                    chk("rd_done",  32'(bus.readDone),    32'(r.done));
                end
            end
        end
    end

    initial begin
        // 1: reset, clear sweep, first request
        resetN = 1'b0;
        repeat (3) step();
        chk_all_zero("reset");
        for (int i = 0; i < 4; i++) push_write(i);
        resetN = 1'b1;
        chk("t1_sr_c0", 32'(bus.storageReady), 32'd0);
        for (int i = 1; i < 16; i++) begin
            step();
            chk("t1_sr_sweep", 32'(bus.storageReady), 32'd0);
        end
        step();
        chk("t1_sr_up",  32'(bus.storageReady), 32'd1);
        chk("t1_newadr", 32'(bus.newAddress),   32'd1);
        chk("t1_ssid0",  32'(bus.SSID),         32'd0);
        chk("t1_hit0",   32'(bus.hitInfo),      32'h2345);

        // 2: four consecutive writes then silence
        for (int i = 0; i < 4; i++) begin
            chk("t2_newadr", 32'(bus.newAddress), 32'd1);
            chk("t2_ssid",   32'(bus.SSID),       32'(i));
            step();
        end
        for (int i = 0; i < 3; i++) begin
            chk("t2_gen_done", 32'(bus.newAddress), 32'd0);
            step();
        end
        chk("t2_wq_drained", 32'(wq.size()), 32'd0);

        // 3: full read-out
        for (int i = 0; i < 4; i++) push_read(i, HIT_REF[i], 1'b1, 1'b0);
        push_read(15, 16'h0, 1'b0, 1'b1);
        readMemory = 1'b1;
        step();
        readMemory = 1'b0;
        chk("t3_sr_busy", 32'(bus.storageReady), 32'd0);
        for (int k = 0; k < 16; k++) begin
            step();
            chk("t3_rssid", 32'(bus.readSSID),  32'(k));
            chk("t3_rrdy",  32'(bus.readReady), 32'(k < 4));
            chk("t3_rdone", 32'(bus.readDone),  32'(k == 15));
            if (k >= 4) chk("t3_rhit_empty", 32'(bus.readHitInfo), 32'd0);
        end
        step();
        chk("t3_sr_back", 32'(bus.storageReady), 32'd1);
        chk("t3_done_1c", 32'(bus.readDone),     32'd0);

        // 4: bulk clear, then read-out of an empty store
        clearMemory = 1'b1;
        step();
        clearMemory = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("t4_sr_clear", 32'(bus.storageReady), 32'd0);
            step();
        end
        chk("t4_sr_up", 32'(bus.storageReady), 32'd1);
        repeat (16) step();
        push_read(15, 16'h0, 1'b0, 1'b1);
        readMemory = 1'b1;
        step();
        readMemory = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            chk("t4_rssid", 32'(bus.readSSID),    32'(k));
            chk("t4_rrdy",  32'(bus.readReady),   32'd0);
            chk("t4_rhit",  32'(bus.readHitInfo), 32'd0);
        end
        step();
        chk("t4_sr_back", 32'(bus.storageReady), 32'd1);

        // 5a: clear and read together -> clear wins
        clearMemory = 1'b1;
        readMemory  = 1'b1;
        step();
        clearMemory = 1'b0;
        readMemory  = 1'b0;
        chk("t5_sr_busy", 32'(bus.storageReady), 32'd0);
        step();
        chk("t5_not_read", 32'(bus.readSSID), 32'd15);
        repeat (14) step();
        chk("t5_sr_sweep", 32'(bus.storageReady), 32'd0);
        step();
        chk("t5_sr_up", 32'(bus.storageReady), 32'd1);

        // 5b: abort a read-out at word 5
        readMemory = 1'b1;
        step();
        readMemory = 1'b0;
        repeat (6) step();
        chk("t5_at_word5", 32'(bus.readSSID), 32'd5);
        clearMemory = 1'b1;
        step();
        clearMemory = 1'b0;
        chk("t5_abort_sr", 32'(bus.storageReady), 32'd0);
        for (int i = 1; i < 16; i++) begin
            step();
            chk("t5_abort_sr",   32'(bus.storageReady), 32'd0);
            chk("t5_abort_done", 32'(bus.readDone),     32'd0);
            chk("t5_abort_rdy",  32'(bus.readReady),    32'd0);
        end
        step();
        chk("t5_abort_sr_up", 32'(bus.storageReady), 32'd1);

        // 6: reset in the middle of the write burst
        resetN = 1'b0;
        step();
        push_write(0);
        push_write(1);
        resetN = 1'b1;
        repeat (16) step();
        chk("t6_first_ssid", 32'(bus.SSID), 32'd0);
        step();
        step();
        chk("t6_at_ssid2", 32'(bus.SSID), 32'd2);
        resetN = 1'b0;
        #1;
        chk_all_zero("t6_async");
        chk("t6_wq_drained", 32'(wq.size()), 32'd0);
        step();
        for (int i = 0; i < 4; i++) push_write(i);
        resetN = 1'b1;
        repeat (15) step();
        chk("t6_sr_sweep", 32'(bus.storageReady), 32'd0);
        step();
        chk("t6_restart_new",  32'(bus.newAddress), 32'd1);
        chk("t6_restart_ssid", 32'(bus.SSID),       32'd0);
        chk("t6_restart_hit",  32'(bus.hitInfo),    32'h2345);
        repeat (4) step();
        chk("t6_gen_done", 32'(bus.newAddress), 32'd0);
        for (int i = 0; i < 4; i++) push_read(i, HIT_REF[i], 1'b1, 1'b0);
        push_read(15, 16'h0, 1'b0, 1'b1);
        readMemory = 1'b1;
        step();
        readMemory = 1'b0;
        repeat (17) step();
        chk("t6_sr_back", 32'(bus.storageReady), 32'd1);

        repeat (3) step();
        chk("end_wq_empty", 32'(wq.size()), 32'd0);
        chk("end_rq_empty", 32'(rq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
